// File: rtl/pingpong_pkg.sv
// Constants and types shared by the ping-pong splitter and merger.
package pingpong_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    SEL1 = 1'b0,
    SEL2 = 1'b1
  } pp_sel_e;

  // A configured size of zero behaves as one.
  function automatic cnt_t eff_size(input cnt_t v);
    return (v == '0) ? cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/pingpong_merger_if.sv
// One AXI-Stream channel (data, keep, last, valid/ready).
interface pingpong_merger_if #(
  parameter  int unsigned DW = 512,
  localparam int unsigned KW = DW / 8
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice; upstream ready comes straight from a flop.
module axis_skid_buffer #(
  parameter  int unsigned DW = 512,
  localparam int unsigned KW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_tdata,
  input  logic [KW-1:0] in_tkeep,
  input  logic          in_tlast,
  input  logic          in_tvalid,
  output logic          in_tready,
  output logic [DW-1:0] out_tdata,
  output logic [KW-1:0] out_tkeep,
  output logic          out_tlast,
  output logic          out_tvalid,
  input  logic          out_tready
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t out_q, out_d, skid_q, skid_d, in_beat;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q, ready_d;
  logic  in_fire;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    in_beat      = '{data: in_tdata, keep: in_tkeep, last: in_tlast};
    in_fire      = in_tvalid && ready_q;
    if (!out_valid_q || out_tready) begin
      // Output slot frees up: drain the skid entry first to keep order.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_beat;
      end
    end else if (in_fire) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_tready  = ready_q;
  assign out_tdata  = out_q.data;
  assign out_tkeep  = out_q.keep;
  assign out_tlast  = out_q.last;
  assign out_tvalid = out_valid_q;

endmodule

// File: rtl/pingpong_merger.sv
// Merges the two ping-pong lanes back into one stream, group by group,
// regenerating TLAST from a beat counter and flagging inconsistent input TLAST.
module pingpong_merger
  import pingpong_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         PACKET_SIZE,
  input  logic [CNT_W-1:0]         PP_GROUP,
  pingpong_merger_if.slave         axis_in1,
  pingpong_merger_if.slave         axis_in2,
  pingpong_merger_if.master        axis_out,
  output logic                     LAST_ERR
);

  localparam int unsigned KW = DW / 8;

  pp_sel_e       state_q, state_d;
  cnt_t          beat_cnt_q, beat_cnt_d;
  cnt_t          pkt_cnt_q, pkt_cnt_d;
  cnt_t          psize_q, psize_d;
  cnt_t          gsize_q, gsize_d;
  logic          last_err_q, last_err_d;

  logic          skid_ready;
  logic          sel_valid, sel_last, fire;
  logic [DW-1:0] sel_data;
  logic [KW-1:0] sel_keep;
  logic          group_start, beat_last;
  cnt_t          cur_psize, cur_gsize;

  // Lane select: only the active lane ever sees ready.
  always_comb begin
    sel_valid = axis_in1.tvalid;
    sel_data  = axis_in1.tdata;
    sel_keep  = axis_in1.tkeep;
    sel_last  = axis_in1.tlast;
    if (state_q == SEL2) begin
      sel_valid = axis_in2.tvalid;
      sel_data  = axis_in2.tdata;
      sel_keep  = axis_in2.tkeep;
      sel_last  = axis_in2.tlast;
    end
    fire = sel_valid && skid_ready;
  end

  assign axis_in1.tready = skid_ready && (state_q == SEL1);
  assign axis_in2.tready = skid_ready && (state_q == SEL2);

  // Beat/packet counting and lane switching; sizes are sampled at group start.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    psize_d     = psize_q;
    gsize_d     = gsize_q;
    last_err_d  = 1'b0;
    group_start = (beat_cnt_q == '0) && (pkt_cnt_q == '0);
    cur_psize   = group_start ? eff_size(PACKET_SIZE) : psize_q;
    cur_gsize   = group_start ? eff_size(PP_GROUP) : gsize_q;
    beat_last   = (beat_cnt_q == cur_psize - cnt_t'(1));
    if (fire) begin
      last_err_d = (sel_last != beat_last);
      if (group_start) begin
        psize_d = cur_psize;
        gsize_d = cur_gsize;
      end
      if (beat_last) begin
        beat_cnt_d = '0;
        if (pkt_cnt_q == cur_gsize - cnt_t'(1)) begin
          pkt_cnt_d = '0;
          state_d   = (state_q == SEL1) ? SEL2 : SEL1;
        end else begin
          pkt_cnt_d = pkt_cnt_q + cnt_t'(1);
        end
      end else begin
        beat_cnt_d = beat_cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEL1;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      psize_q    <= '0;
      gsize_q    <= '0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      psize_q    <= psize_d;
      gsize_q    <= gsize_d;
      last_err_q <= last_err_d;
    end
  end

  assign LAST_ERR = last_err_q;

  axis_skid_buffer #(.DW(DW)) u_out_slice (
    .clk        (clk),
    .rst        (reset),
    .in_tdata   (sel_data),
    .in_tkeep   (sel_keep),
    .in_tlast   (beat_last),
    .in_tvalid  (sel_valid),
    .in_tready  (skid_ready),
    .out_tdata  (axis_out.tdata),
    .out_tkeep  (axis_out.tkeep),
    .out_tlast  (axis_out.tlast),
    .out_tvalid (axis_out.tvalid),
    .out_tready (axis_out.tready)
  );

endmodule

// File: tb/tb_pingpong_merger.sv
// Directed bench for pingpong_merger: lane order, TLAST regeneration,
// LAST_ERR timing, backpressure hold, zero sizes and asynchronous reset.
module tb_pingpong_merger;

  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] psize_in, group_in;
  logic        last_err;

  pingpong_merger_if #(.DW(DW)) in1_if ();
  pingpong_merger_if #(.DW(DW)) in2_if ();
  pingpong_merger_if #(.DW(DW)) out_if ();

  pingpong_merger #(.DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .PACKET_SIZE (psize_in),
    .PP_GROUP    (group_in),
    .axis_in1    (in1_if),
    .axis_in2    (in2_if),
    .axis_out    (out_if),
    .LAST_ERR    (last_err)
  );

  always #5 clk = ~clk;

  int n_tests, n_fail;

  // stimulus configuration
  bit v1_en, v2_en, rnd_rdy;
  int lim1, lim2, psz_tb, tl_mode, tl_idx;
  // run-time state
  int idx1, idx2, cyc;
  bit pend1, pend2, stalled;
  logic [63:0] held;
  logic [63:0] outq[$];
  int outcyc[$], errcyc[$], in1cyc[$], in2cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int k, input int p, input int g);
    int pg, blk, i;
    logic last;
    logic [31:0] d;
    logic [3:0] kp;
    pg   = p * g;
    blk  = k / pg;
    i    = (blk / 2) * pg + k % pg;
    last = ((k % p) == p - 1);
    if (blk % 2 == 0) begin
      d  = 32'h0100_0000 + 32'(i);
      kp = 4'(i + 1);
    end else begin
      d  = 32'h0200_0000 + 32'(i);
      kp = ~4'(i);
    end
    return {27'b0, last, kp, d};
  endfunction

  function automatic logic lane_tlast(input int lane, input int idx);
    if (tl_mode == 1 && lane == 1) return (idx == tl_idx);
    return ((idx % psz_tb) == psz_tb - 1);
  endfunction

  function automatic logic [63:0] cur_out();
    return {27'b0, out_if.tlast, out_if.tkeep, out_if.tdata};
  endfunction

  task automatic clear_tb();
    idx1 = 0; idx2 = 0; cyc = 0;
    pend1 = 0; pend2 = 0; stalled = 0; held = '0;
    outq.delete(); outcyc.delete(); errcyc.delete();
    in1cyc.delete(); in2cyc.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in1_if.tvalid = 1'b0;
    in2_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_tb();
  endtask

  // One cycle: drive at the falling edge, then record what the next rising edge will transfer.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pend1) idx1++;
    if (pend2) idx2++;
    in1_if.tvalid = v1_en && (idx1 < lim1);
    in1_if.tdata  = 32'h0100_0000 + 32'(idx1);
    in1_if.tkeep  = 4'(idx1 + 1);
    in1_if.tlast  = lane_tlast(1, idx1);
    in2_if.tvalid = v2_en && (idx2 < lim2);
    in2_if.tdata  = 32'h0200_0000 + 32'(idx2);
    in2_if.tkeep  = ~4'(idx2);
    in2_if.tlast  = lane_tlast(2, idx2);
    out_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stalled) check("stall_hold", cur_out(), held);
    pend1 = in1_if.tvalid && in1_if.tready;
    pend2 = in2_if.tvalid && in2_if.tready;
    if (pend1) in1cyc.push_back(cyc);
    if (pend2) in2cyc.push_back(cyc);
    if (out_if.tvalid && out_if.tready) begin
      outq.push_back(cur_out());
      outcyc.push_back(cyc);
    end
    stalled = out_if.tvalid && !out_if.tready;
    held    = cur_out();
    if (last_err) errcyc.push_back(cyc);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ovalid"}, 64'(out_if.tvalid), 64'd0);
    check({pfx, "_odata"},  64'(out_if.tdata),  64'd0);
    check({pfx, "_okeep"},  64'(out_if.tkeep),  64'd0);
    check({pfx, "_olast"},  64'(out_if.tlast),  64'd0);
    check({pfx, "_lasterr"}, 64'(last_err),     64'd0);
    check({pfx, "_rdy1"},   64'(in1_if.tready), 64'd0);
    check({pfx, "_rdy2"},   64'(in2_if.tready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit in2_seen, found;
    int got1;
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    psize_in = 32'd4; group_in = 32'd2;
    in1_if.tvalid = 0; in1_if.tdata = '0; in1_if.tkeep = '0; in1_if.tlast = 0;
    in2_if.tvalid = 0; in2_if.tdata = '0; in2_if.tkeep = '0; in2_if.tlast = 0;
    out_if.tready = 1'b0;
    v1_en = 0; v2_en = 0; rnd_rdy = 0; lim1 = 1000; lim2 = 1000;
    psz_tb = 4; tl_mode = 0; tl_idx = 0;
    clear_tb();

    // reset values, then first cycle after release
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rel_rdy1", 64'(in1_if.tready), 64'd1);
    check("rel_rdy2", 64'(in2_if.tready), 64'd0);

    // T1: 4-beat packets, groups of 2, both lanes streaming
    psize_in = 32'd4; group_in = 32'd2; psz_tb = 4;
    v1_en = 1; v2_en = 1; rnd_rdy = 0; tl_mode = 0;
    apply_reset();
    repeat (22) step();
    check("t1_cnt", 64'(outq.size() >= 16), 64'd1);
    for (int k = 0; k < 16 && k < outq.size(); k++)
      check($sformatf("t1_beat%0d", k), outq[k], exp_beat(k, 4, 2));
    if (outq.size() >= 16) check("t1_nobubble", 64'(outcyc[15] - outcyc[0]), 64'd15);
    check("t1_err", 64'(errcyc.size()), 64'd0);

    // T2: only lane 2 offers data; nothing may move until lane 1 fills a group
    v1_en = 0; v2_en = 1;
    apply_reset();
    in2_seen = 0;
    repeat (20) begin
      step();
      in2_seen |= in2_if.tready;
    end
    check("t2_out", 64'(outq.size()), 64'd0);
    check("t2_rdy2", 64'(in2_seen), 64'd0);
    v1_en = 1; found = 0; got1 = -1;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (in2_if.tready) begin
        found = 1;
        got1 = in1cyc.size();
      end
    end
    check("t2_grp", 64'(got1), 64'd8);

    // T3: 3-beat packets, lane 1 raises TLAST one beat early
    psize_in = 32'd3; group_in = 32'd2; psz_tb = 3;
    v1_en = 1; v2_en = 0; lim1 = 3; tl_mode = 1; tl_idx = 1;
    apply_reset();
    repeat (10) step();
    check("t3_cnt", 64'(outq.size()), 64'd3);
    for (int k = 0; k < 3 && k < outq.size(); k++)
      check($sformatf("t3_beat%0d", k), outq[k], exp_beat(k, 3, 2));
    check("t3_errcnt", 64'(errcyc.size()), 64'd2);
    if (errcyc.size() >= 2 && in1cyc.size() >= 3) begin
      check("t3_err0_t", 64'(errcyc[0]), 64'(in1cyc[1] + 1));
      check("t3_err1_t", 64'(errcyc[1]), 64'(in1cyc[2] + 1));
    end
    lim1 = 1000; tl_mode = 0;

    // T4: random backpressure, 5-beat packets, groups of 3
    psize_in = 32'd5; group_in = 32'd3; psz_tb = 5;
    v1_en = 1; v2_en = 1; rnd_rdy = 1;
    apply_reset();
    for (int c = 0; c < 800 && outq.size() < 60; c++) step();
    check("t4_cnt", 64'(outq.size() >= 60), 64'd1);
    for (int k = 0; k < 60 && k < outq.size(); k++)
      check($sformatf("t4_beat%0d", k), outq[k], exp_beat(k, 5, 3));
    check("t4_err", 64'(errcyc.size()), 64'd0);
    rnd_rdy = 0;

    // T5: zero sizes behave as one
    psize_in = 32'd0; group_in = 32'd0; psz_tb = 1;
    apply_reset();
    repeat (14) step();
    check("t5_cnt", 64'(outq.size() >= 10), 64'd1);
    for (int k = 0; k < 10 && k < outq.size(); k++)
      check($sformatf("t5_beat%0d", k), outq[k], exp_beat(k, 1, 1));
    check("t5_err", 64'(errcyc.size()), 64'd0);

    // T6: asynchronous reset in the middle of a lane-2 packet
    psize_in = 32'd4; group_in = 32'd1; psz_tb = 4;
    apply_reset();
    for (int c = 0; c < 40 && in2cyc.size() < 2; c++) step();
    check("t6_reach", 64'(in2cyc.size()), 64'd2);
    reset = 1'b1;
    #1;
    check_reset_values("t6");
    @(negedge clk);
    reset = 1'b0;
    clear_tb();
    repeat (10) step();
    check("t6_cnt", 64'(outq.size() >= 5), 64'd1);
    for (int k = 0; k < 5 && k < outq.size(); k++)
      check($sformatf("t6_beat%0d", k), outq[k], exp_beat(k, 4, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_merger.md
# pingpong_merger

Recombines the two AXI-Stream halves produced by the ping-pong splitter into one stream. It takes PP_GROUP packets of PACKET_SIZE beats from input 1, then PP_GROUP packets from input 2, and repeats. It regenerates TLAST on the merged output and flags any input whose TLAST disagrees with the configured packet length. It sits downstream of the two parallel ping-pong processing lanes, ahead of the single-stream sink.

## Interface
- DW, 512, data width in bits; TKEEP width is DW/8
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- PACKET_SIZE  in  32  beats per packet; 0 treated as 1
- PP_GROUP  in  32  packets per ping-pong group; 0 treated as 1
- AXIS_IN1_TDATA / TKEEP / TLAST / TVALID  in  DW / DW/8 / 1 / 1  lane-1 stream
- AXIS_IN1_TREADY  out  1  lane-1 ready
- AXIS_IN2_TDATA / TKEEP / TLAST / TVALID  in  DW / DW/8 / 1 / 1  lane-2 stream
- AXIS_IN2_TREADY  out  1  lane-2 ready
- AXIS_OUT_TDATA / TKEEP / TLAST / TVALID  out  DW / DW/8 / 1 / 1  merged stream, registered
- AXIS_OUT_TREADY  in  1  downstream ready
- LAST_ERR  out  1  one-cycle pulse: input TLAST mismatched the beat counter

## Operation
- FSM states: SEL1 (accept from lane 1) and SEL2 (accept from lane 2). Reset state is SEL1.
- Only the selected lane sees TREADY. The unselected lane's TREADY is held at 0.
- Selected TREADY equals the output slice's ready (upstream-ready).
- An input transfer is selected TVALID && TREADY. Each transfer increments beat_cnt.
- Effective sizes: psize = max(PACKET_SIZE, 1) and gsize = max(PP_GROUP, 1).
  - Both are latched on the first beat of each group (beat_cnt==0 && pkt_cnt==0).
  - Mid-group changes are ignored.
- Last beat of a packet: beat_cnt == psize-1.
  - Output TLAST is forced to 1; beat_cnt returns to 0; pkt_cnt increments.
  - If pkt_cnt == gsize-1, pkt_cnt returns to 0 and the FSM toggles SEL1↔SEL2.
- Output TLAST is driven by the counter, not by the input. Input TLAST only feeds LAST_ERR.
- LAST_ERR pulses on any transfer where input TLAST != (beat_cnt == psize-1). It is registered: asserted the cycle after the transfer.
- TDATA and TKEEP pass through unchanged.
- Counters are 32-bit. Compares use `==` on the terminal value, so there is no wrap-around concern below 2^32-1.
- Mid-packet stalls: the FSM never switches on idle. It waits indefinitely on the selected lane, even if the other lane is valid.

## Timing
- Latency: 1 cycle, input transfer to AXIS_OUT_TVALID.
- Throughput: 1 beat/cycle sustained, including across lane switches. The beat after a switch is accepted from the new lane on the very next cycle.
- Output slice is a 2-entry skid buffer, so upstream TREADY is a registered signal.
- Once asserted, AXIS_OUT_TVALID/TDATA/TKEEP/TLAST hold stable until AXIS_OUT_TREADY.
- Reset values:
  - AXIS_OUT_TVALID=0, TDATA=0, TKEEP=0, TLAST=0, LAST_ERR=0.
  - Both input TREADY=0.
  - FSM=SEL1, beat_cnt=0, pkt_cnt=0.
- First cycle after reset deassertion: AXIS_IN1_TREADY=1, AXIS_IN2_TREADY=0.
- Reset mid-packet: all state is discarded immediately (asynchronous). Merging restarts on lane 1 at beat 0, and any buffered skid data is dropped.

## Structure
- Shared package pingpong_pkg:
  - FSM state encoding (SEL1=1'b0, SEL2=1'b1).
  - Counter width constant CNT_W=32.
  - The splitter uses the same constants.
- One sub-module: axis_skid_buffer (parameter DW), which holds TDATA, TKEEP and TLAST. It is reusable on the splitter outputs.

## Test plan
- PACKET_SIZE=4, PP_GROUP=2, both lanes always valid, OUT_TREADY=1 → output carries 8 beats from lane 1 then 8 from lane 2, TLAST on beats 4, 8, 12, 16, no bubbles, LAST_ERR never set.
- Lane 2 valid and lane 1 idle after reset → zero output beats; AXIS_IN2_TREADY stays 0 until lane 1 supplies a full group.
- PACKET_SIZE=3, lane 1 asserts TLAST on beat 2 → LAST_ERR pulses one cycle after beat 2 and again after beat 3; output TLAST only on beat 3.
- Random OUT_TREADY (50%) with PACKET_SIZE=5, PP_GROUP=3 over 60 beats → output sequence matches the reference lane order exactly, and TDATA is stable while stalled.
- PACKET_SIZE=0, PP_GROUP=0 → every beat is TLAST, and lanes alternate every beat.
- Assert reset on beat 2 of a lane-2 packet → all outputs return to reset values the same cycle; after release, lane 1 is selected with beat_cnt=0.
